// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of exactly N rising edges on pulse_o. Each pulse is HIGH_CYCLES
// cycles high followed by LOW_CYCLES cycles low. The block uses a start/done handshake.
//
// Optional feature macro: PULSE_ABORT_EN. When it is defined, the block adds the abort_i port,
// which ends a train early.
//
// Ports:
//   clk      in          system clock, rising edge
//   rst_i    in          asynchronous active-high reset
//   start_i  in          request a train; sampled only when idle
//   count_i  in  WIDTH   number of pulses; captured when the start is accepted
//   abort_i  in          (PULSE_ABORT_EN only) end the train early; sampled in HIGH/LOW
//   pulse_o  out         pulse train
//   busy_o   out         high while a train is in progress (HIGH or LOW)
//   done_o   out         one-cycle completion strobe
//   sent_o   out WIDTH   pulses completed in the current or last train
module pulse_train_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] count_i,
`ifdef PULSE_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sent_o
);

  localparam int unsigned MaxCycles = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned PhaseW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [PhaseW-1:0] HighLast = PhaseW'(HIGH_CYCLES - 1);
  localparam logic [PhaseW-1:0] LowLast  = PhaseW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [WIDTH-1:0]    sent_q, sent_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                abort;

`ifdef PULSE_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sent_d   = sent_q;
    phase_d  = phase_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          target_d = count_i;
          sent_d   = '0;
          phase_d  = '0;
          state_d  = (count_i != '0) ? StHigh : StDone;
        end
      end
      StHigh: begin
        if (abort) begin
          // The rising edge of this pulse was already emitted, so it is counted.
          sent_d  = sent_q + WIDTH'(1);
          phase_d = '0;
          state_d = StDone;
        end else if (phase_q == HighLast) begin
          sent_d  = sent_q + WIDTH'(1);
          phase_d = '0;
          state_d = StLow;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StLow: begin
        if (abort) begin
          phase_d = '0;
          state_d = StDone;
        end else if (phase_q == LowLast) begin
          phase_d = '0;
          state_d = (sent_q == target_q) ? StDone : StHigh;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= '0;
      sent_q   <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sent_q   <= sent_d;
      phase_q  <= phase_d;
    end
  end

  // Outputs decode from registered state only.
  assign pulse_o = (state_q == StHigh);
  assign busy_o  = (state_q == StHigh) || (state_q == StLow);
  assign done_o  = (state_q == StDone);
  assign sent_o  = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  localparam int unsigned W = 8;
  localparam int unsigned H = 2;
  localparam int unsigned L = 2;
  localparam int unsigned P = H + L;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] count_i;
  logic         pulse_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sent_o;
`ifdef PULSE_ABORT_EN
  logic         abort_i;
`endif

  int checks = 0;
  int errors = 0;

  // Downstream counter model: 2-stage rising-edge detector on pulse_o.
  logic edge_clr;
  logic p1, p2;
  int   edge_cnt;

  pulse_train_gen #(
    .WIDTH      (W),
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L)
  ) dut (
    .clk    (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .count_i(count_i),
`ifdef PULSE_ABORT_EN
    .abort_i(abort_i),
`endif
    .pulse_o(pulse_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .sent_o (sent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= pulse_o;
    p2 <= p1;
    if (edge_clr) edge_cnt <= 0;
    else if (p1 && !p2) edge_cnt <= edge_cnt + 1;
  end

  // Leaves the bench at the negedge following the accepting edge k (offset m = 0).
  task automatic start_train(input logic [W-1:0] n);
    @(negedge clk);
    count_i  = n;
    start_i  = 1'b1;
    edge_clr = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    edge_clr = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({pulse_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got p/b/d=%b expected 000", {pulse_o, busy_o, done_o});
    end
    checks++;
    if (sent_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_sent got %0d expected 0", sent_o);
    end
    #8;
    rst_i = 1'b0;
  endtask

  task automatic test_basic;
    logic [12:0] exp_pulse;
    logic [12:0] exp_busy;
    logic [12:0] exp_done;
    exp_pulse = 13'b0_0011_0011_0011;
    exp_busy  = 13'b0_1111_1111_1111;
    exp_done  = 13'b1_0000_0000_0000;
    start_train(8'd3);
    for (int m = 0; m <= 12; m++) begin
      checks++;
      if ({pulse_o, busy_o, done_o} !== {exp_pulse[m], exp_busy[m], exp_done[m]}) begin
        errors++;
        $display("FAIL basic_wave m=%0d got p/b/d=%b expected %b", m,
                 {pulse_o, busy_o, done_o}, {exp_pulse[m], exp_busy[m], exp_done[m]});
      end
      if (m < 12) @(negedge clk);
    end
    checks++;
    if (sent_o !== 8'd3) begin
      errors++;
      $display("FAIL basic_sent got %0d expected 3", sent_o);
    end
    checks++;
    if (edge_cnt != 3) begin
      errors++;
      $display("FAIL basic_edges got %0d expected 3", edge_cnt);
    end
  endtask

  task automatic test_zero;
    start_train(8'd0);
    checks++;
    if ({pulse_o, busy_o, done_o} !== 3'b001) begin
      errors++;
      $display("FAIL zero_done got p/b/d=%b expected 001", {pulse_o, busy_o, done_o});
    end
    checks++;
    if (sent_o !== 8'd0) begin
      errors++;
      $display("FAIL zero_sent got %0d expected 0", sent_o);
    end
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      checks++;
      if ({pulse_o, busy_o, done_o} !== 3'b000) begin
        errors++;
        $display("FAIL zero_idle m=%0d got p/b/d=%b expected 000", m, {pulse_o, busy_o, done_o});
      end
    end
  endtask

  task automatic test_ignore_start;
    int bad;
    logic exp_p;
    bad = 0;
    start_train(8'd255);
    for (int m = 0; m < 255 * P; m++) begin
      exp_p = ((m % P) < H);
      if (pulse_o !== exp_p || busy_o !== 1'b1 || done_o !== 1'b0) bad++;
      if (m == 100) begin
        start_i = 1'b1;
        count_i = 8'd5;
      end
      if (m == 101) start_i = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_wave got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL long_done got d/b=%b%b expected 10", done_o, busy_o);
    end
    checks++;
    if (sent_o !== 8'd255) begin
      errors++;
      $display("FAIL long_sent got %0d expected 255", sent_o);
    end
    checks++;
    if (edge_cnt != 255) begin
      errors++;
      $display("FAIL long_edges got %0d expected 255", edge_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp_pulse;
    exp_pulse = 9'b0_0011_0011;
    start_train(8'd10);
    for (int m = 0; m < 16; m++) begin
      if (m == 14) begin
        checks++;
        if (sent_o !== 8'd4) begin
          errors++;
          $display("FAIL mid_sent4 got %0d expected 4", sent_o);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulse_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse5 got %b expected 1", pulse_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({pulse_o, busy_o, done_o} !== 3'b000 || sent_o !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got p/b/d=%b sent=%0d expected 000 sent=0",
               {pulse_o, busy_o, done_o}, sent_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    start_train(8'd2);
    for (int m = 0; m <= 8; m++) begin
      checks++;
      if (pulse_o !== exp_pulse[m] || done_o !== (m == 8)) begin
        errors++;
        $display("FAIL after_reset_wave m=%0d got p/d=%b%b expected %b%b", m, pulse_o, done_o,
                 exp_pulse[m], (m == 8));
      end
      if (m < 8) @(negedge clk);
    end
    checks++;
    if (sent_o !== 8'd2 || edge_cnt != 2) begin
      errors++;
      $display("FAIL after_reset_count got sent=%0d edges=%0d expected 2 2", sent_o, edge_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] exp_pulse;
    logic [10:0] exp_busy;
    logic [10:0] exp_done;
    exp_pulse = 11'b000_1100_0011;
    exp_busy  = 11'b011_1100_1111;
    exp_done  = 11'b100_0001_0000;
    @(negedge clk);
    count_i  = 8'd1;
    start_i  = 1'b1;
    edge_clr = 1'b1;
    @(negedge clk);
    edge_clr = 1'b0;
    // start_i stays high: ignored until the IDLE cycle after DONE.
    for (int m = 0; m <= 10; m++) begin
      checks++;
      if ({pulse_o, busy_o, done_o} !== {exp_pulse[m], exp_busy[m], exp_done[m]}) begin
        errors++;
        $display("FAIL b2b_wave m=%0d got p/b/d=%b expected %b", m,
                 {pulse_o, busy_o, done_o}, {exp_pulse[m], exp_busy[m], exp_done[m]});
      end
      if (m == 6) start_i = 1'b0;
      if (m < 10) @(negedge clk);
    end
    checks++;
    if (sent_o !== 8'd1) begin
      errors++;
      $display("FAIL b2b_sent got %0d expected 1", sent_o);
    end
  endtask

`ifdef PULSE_ABORT_EN
  task automatic test_abort;
    // Abort during the high phase of the third pulse (m = 8,9).
    start_train(8'd6);
    for (int m = 0; m < 8; m++) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if ({pulse_o, busy_o, done_o} !== 3'b001 || sent_o !== 8'd3) begin
      errors++;
      $display("FAIL abort_high got p/b/d=%b sent=%0d expected 001 sent=3",
               {pulse_o, busy_o, done_o}, sent_o);
    end
    // Start with abort also high is accepted; then abort in the low phase after pulse 2.
    abort_i = 1'b1;
    start_train(8'd6);
    abort_i = 1'b0;
    checks++;
    if (pulse_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_start got pulse=%b expected 1", pulse_o);
    end
    for (int m = 0; m < 6; m++) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if ({pulse_o, busy_o, done_o} !== 3'b001 || sent_o !== 8'd2) begin
      errors++;
      $display("FAIL abort_low got p/b/d=%b sent=%0d expected 001 sent=2",
               {pulse_o, busy_o, done_o}, sent_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i    = 1'b0;
    start_i  = 1'b0;
    count_i  = '0;
    edge_clr = 1'b1;
`ifdef PULSE_ABORT_EN
    abort_i  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef PULSE_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Drives a train of exactly N clean rising edges onto one line, with programmable high and low widths and a start/done handshake. It is the transmit side of our edge-counting path: its `pulse_o` feeds a rising-edge counter's enable input, and its `sent_o` equals the value that counter reaches once the train completes. It is used to stimulate and self-check counter blocks, and to issue counted step pulses.

## Interface
Parameters:
- `WIDTH`, 8: width of `count_i` and `sent_o`.
- `HIGH_CYCLES`, 2: clock cycles `pulse_o` stays high per pulse; must be ≥1.
- `LOW_CYCLES`, 2: clock cycles `pulse_o` stays low after each pulse; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `start_i`  in  1  request a train; sampled only in IDLE.
- `count_i`  in  WIDTH  number of pulses to send; captured when the start is accepted.
- `pulse_o`  out  1  pulse train output.
- `busy_o`  out  1  high while a train is in progress.
- `done_o`  out  1  one-cycle completion strobe.
- `sent_o`  out  WIDTH  number of pulses completed in the current or last train.
- `abort_i`  in  1  present only when `PULSE_ABORT_EN` is defined.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- `pulse_o`, `busy_o` and `done_o` decode from registered state only. There is no combinational path from any input to any output.
  - `pulse_o` = (state == HIGH).
  - `busy_o` = (state is HIGH or LOW).
  - `done_o` = (state == DONE).
- IDLE, `start_i` = 1:
  - capture `count_i` into the target register;
  - clear `sent_o` to 0;
  - clear the phase counter;
  - go to HIGH if `count_i` ≠ 0, else go to DONE.
- HIGH: the phase counter runs for HIGH_CYCLES cycles. On the last cycle, `sent_o` increments by 1 and the FSM goes to LOW.
- LOW: the phase counter runs for LOW_CYCLES cycles. On the last cycle, go to DONE if `sent_o` == target, else go to HIGH.
- DONE: lasts one cycle, then go to IDLE.
- `start_i` is ignored outside IDLE. `count_i` changes after capture have no effect.
- `sent_o` holds its final value until the next accepted start.
- Width rules:
  - target ≤ 2^WIDTH−1, so `sent_o` never wraps;
  - the phase counter is wide enough for max(HIGH_CYCLES, LOW_CYCLES).
- Reset, including mid-train: the FSM goes to IDLE immediately, without waiting for a clock edge. `pulse_o`=0, `busy_o`=0, `done_o`=0, `sent_o`=0, target=0.

## Timing
- Call the edge at which the start is accepted edge k.
- `pulse_o` rises after edge k, giving 1 cycle of latency from `start_i` sampled high.
- Pulse j (j = 0..N−1):
  - high during edges k+j·(H+L) .. k+j·(H+L)+H;
  - low for the next L cycles.
- `done_o` is high for exactly the one cycle after edge k+N·(H+L). `busy_o` is low in that cycle.
- With N=0, `done_o` is high in the cycle after edge k and `pulse_o` never rises.
- A new start can be accepted at the first edge after DONE, which gives a back-to-back period of N·(H+L)+2 cycles.
- A downstream counter that samples `pulse_o` through a 2-stage edge detector sees N rising edges. The minimum spacing between edges is H+L ≥ 2 cycles, so none are merged.

## Configuration
- `PULSE_ABORT_EN` defined:
  - adds the `abort_i` port, sampled in HIGH and LOW, with priority over the normal transitions;
  - in HIGH, `pulse_o` falls at the next edge, `sent_o` increments (the edge was already emitted), and the FSM goes to DONE;
  - in LOW, the FSM goes to DONE at the next edge, with `sent_o` unchanged;
  - ignored in IDLE and DONE; if `start_i` and `abort_i` are both high in IDLE, the start is accepted.
- `PULSE_ABORT_EN` undefined: no `abort_i` port, and every accepted train runs to completion.

## Test plan
- Reset values: assert `rst_i` asynchronously between clock edges → all outputs 0 immediately, with no clock edge needed.
- `count_i`=3, defaults H=2, L=2, pulse start at edge k:
  - 3 pulses, each 2 cycles high and 2 cycles low;
  - `done_o` high in the cycle after edge k+12;
  - `sent_o`=3;
  - a downstream rising-edge counter reads 3.
- `count_i`=0 → `pulse_o` stays 0, `done_o` high in the cycle after edge k, `sent_o`=0.
- `count_i`=255, with `start_i` and new `count_i`=5 pulsed mid-train → both ignored; exactly 255 pulses, `sent_o`=255, no wrap.
- `count_i`=10, `rst_i` asserted after 4 pulses → `pulse_o`/`busy_o`/`sent_o` go to 0 immediately; the next start with 2 sends exactly 2 pulses.
- `PULSE_ABORT_EN` defined:
  - `count_i`=6, `abort_i` during the high phase of pulse 3 → `pulse_o` falls next edge, `done_o` follows, `sent_o`=3;
  - `abort_i` during a low phase after pulse 2 → `sent_o`=2.
